// File: rtl/vid_scaled_placer.sv
// Places the scaled picture, read from a first-word-fall-through FIFO, as a
// rectangular window inside the output active area. The rest of the active
// area gets a border colour. Reads that fall inside the window while the FIFO
// has no data are counted as underflow.
module vid_scaled_placer #(
   parameter int C_PORT_NUM        = 4,
   parameter int C_BYTES_PER_PIXEL = 2,
   parameter int C_CNT_W           = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [C_CNT_W-1:0]                        WIN_X_I,
   input  logic [C_CNT_W-1:0]                        WIN_Y_I,
   input  logic [C_CNT_W-1:0]                        WIN_W_I,
   input  logic [C_CNT_W-1:0]                        WIN_H_I,
   input  logic [C_BYTES_PER_PIXEL*8-1:0]            BORDER_PIX_I,
   input  logic                                      VS_I,
   input  logic                                      HS_I,
   input  logic                                      DE_I,
   input  logic                                      FIFO_EMPTY_I,
   input  logic                                      FIFO_RST_BUSY_I,
   input  logic [C_PORT_NUM*C_BYTES_PER_PIXEL*8-1:0] FIFO_DATA_I,
   output logic                                      FIFO_RD_O,
   output logic                                      VS_O,
   output logic                                      HS_O,
   output logic                                      DE_O,
   output logic [C_PORT_NUM*C_BYTES_PER_PIXEL*8-1:0] DATA_O,
   output logic                                      UNDERFLOW_O,
   output logic [C_CNT_W-1:0]                        UFL_CNT_O
);

   localparam int C_PIX_W  = C_BYTES_PER_PIXEL * 8;
   localparam int C_DATA_W = C_PORT_NUM * C_PIX_W;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t               state_q, state_d;

   logic                 vs_d1_q, de_d1_q;
   logic                 vs_rise, de_fall;

   logic [C_CNT_W-1:0]   win_x_q, win_y_q, win_w_q, win_h_q;
   logic [C_PIX_W-1:0]   border_q;

   logic [C_CNT_W-1:0]   x_cnt_q, x_cnt_d;
   logic [C_CNT_W-1:0]   y_cnt_q, y_cnt_d;
   logic [C_CNT_W-1:0]   ufl_cnt_q, ufl_cnt_d;
   logic                 ufl_flag_q;

   logic [C_DATA_W-1:0]  data_q;
   logic                 de_q, vs_q, hs_q;

   logic [C_CNT_W:0]     x_end, y_end;
   logic                 in_win, avail, win_beat, underflow;

   assign vs_rise = VS_I & ~vs_d1_q;
   assign de_fall = ~DE_I & de_d1_q;

   // Window edges are summed one bit wider so a window near the top of the
   // counter range cannot wrap back to a small value.
   assign x_end = {1'b0, win_x_q} + {1'b0, win_w_q};
   assign y_end = {1'b0, win_y_q} + {1'b0, win_h_q};

   // A zero width or height gives an empty range, so no special case is needed.
   // A beat that coincides with vs_rise still sees the previous frame's
   // counters, so it is forced outside the window.
   assign in_win = ({1'b0, y_cnt_q} >= {1'b0, win_y_q}) & ({1'b0, y_cnt_q} < y_end) &
                   ({1'b0, x_cnt_q} >= {1'b0, win_x_q}) & ({1'b0, x_cnt_q} < x_end) &
                   ~vs_rise;

   assign avail = ~FIFO_EMPTY_I & ~FIFO_RST_BUSY_I;

   // Edge-detect history for VS and DE.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block evaluation order.
      if (rst) begin
         vs_d1_q <= 1'b0;
         de_d1_q <= 1'b0;
      end else begin
         vs_d1_q <= VS_I;
         de_d1_q <= DE_I;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state, FIFO pop and underflow detection.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d   = state_q;
      win_beat  = 1'b0;
      FIFO_RD_O = 1'b0;
      underflow = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (vs_rise) state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            win_beat  = DE_I & in_win;
            // A pop during reset would drop a beat the next frame needs.
            FIFO_RD_O = win_beat & avail & ~rst;
            underflow = win_beat & ~avail;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Position and underflow counters: cleared per frame, saturating, never wrap.
   always_comb begin
      x_cnt_d   = x_cnt_q;
      y_cnt_d   = y_cnt_q;
      ufl_cnt_d = ufl_cnt_q;
      if (vs_rise) begin
         x_cnt_d   = '0;
         y_cnt_d   = '0;
         ufl_cnt_d = '0;
      end else if (state_q == S_ACTIVE) begin
         if (de_fall)
            x_cnt_d = '0;
         else if (DE_I && (x_cnt_q != '1))
            x_cnt_d = x_cnt_q + 1'b1;
         if (de_fall && (y_cnt_q != '1))
            y_cnt_d = y_cnt_q + 1'b1;
         if (underflow && (ufl_cnt_q != '1))
            ufl_cnt_d = ufl_cnt_q + 1'b1;
      end
   end

   // Counter registers and the sticky underflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         ufl_cnt_q  <= '0;
         ufl_flag_q <= 1'b0;
      end else begin
         x_cnt_q   <= x_cnt_d;
         y_cnt_q   <= y_cnt_d;
         ufl_cnt_q <= ufl_cnt_d;
         if (underflow) ufl_flag_q <= 1'b1;
      end
   end

   // Window geometry and border colour are frozen for the whole frame at vs_rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_x_q  <= '0;
         win_y_q  <= '0;
         win_w_q  <= '0;
         win_h_q  <= '0;
         border_q <= '0;
      end else if (vs_rise) begin
         win_x_q  <= WIN_X_I;
         win_y_q  <= WIN_Y_I;
         win_w_q  <= WIN_W_I;
         win_h_q  <= WIN_H_I;
         border_q <= BORDER_PIX_I;
      end
   end

   // Output stage: timing and pixels share exactly one cycle of latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         de_q   <= 1'b0;
         vs_q   <= 1'b0;
         hs_q   <= 1'b0;
      end else begin
         data_q <= FIFO_RD_O ? FIFO_DATA_I : {C_PORT_NUM{border_q}};
         de_q   <= DE_I & (state_q == S_ACTIVE);
         vs_q   <= VS_I;
         hs_q   <= HS_I;
      end
   end

   assign DATA_O      = data_q;
   assign DE_O        = de_q;
   assign VS_O        = vs_q;
   assign HS_O        = hs_q;
   assign UNDERFLOW_O = ufl_flag_q;
   assign UFL_CNT_O   = ufl_cnt_q;

endmodule

// File: tb/tb_vid_scaled_placer.sv
// Directed bench for vid_scaled_placer: 6 lines of 16 DE beats per frame,
// with a FIFO model whose head beat k carries the value k in lane 0.
module tb_vid_scaled_placer;

   localparam logic [15:0] BORDER = 16'h1080;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] WIN_X_I, WIN_Y_I, WIN_W_I, WIN_H_I;
   logic [15:0] BORDER_PIX_I;
   logic        VS_I, HS_I, DE_I;
   logic        FIFO_EMPTY_I, FIFO_RST_BUSY_I;
   logic [63:0] FIFO_DATA_I;
   logic        FIFO_RD_O, VS_O, HS_O, DE_O;
   logic [63:0] DATA_O;
   logic        UNDERFLOW_O;
   logic [15:0] UFL_CNT_O;

   // FIFO model: a read pointer over beats 1..fifo_len.
   int          rd_ptr   = 0;
   int          fifo_len = 0;
   logic        fifo_flush = 1'b0;

   int          total = 0;
   int          bad   = 0;
   logic        rd_now;
   logic        sticky_exp = 1'b0;
   logic [63:0] border_exp = '0;
   int          cur_frame = 0, cur_line = 0, cur_beat = 0;

   vid_scaled_placer #(
      .C_PORT_NUM(4), .C_BYTES_PER_PIXEL(2), .C_CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst),
      .WIN_X_I(WIN_X_I), .WIN_Y_I(WIN_Y_I), .WIN_W_I(WIN_W_I), .WIN_H_I(WIN_H_I),
      .BORDER_PIX_I(BORDER_PIX_I),
      .VS_I(VS_I), .HS_I(HS_I), .DE_I(DE_I),
      .FIFO_EMPTY_I(FIFO_EMPTY_I), .FIFO_RST_BUSY_I(FIFO_RST_BUSY_I),
      .FIFO_DATA_I(FIFO_DATA_I),
      .FIFO_RD_O(FIFO_RD_O), .VS_O(VS_O), .HS_O(HS_O), .DE_O(DE_O),
      .DATA_O(DATA_O), .UNDERFLOW_O(UNDERFLOW_O), .UFL_CNT_O(UFL_CNT_O)
   );

   always #5 clk = ~clk;

   assign FIFO_DATA_I  = 64'(rd_ptr + 1);
   assign FIFO_EMPTY_I = (rd_ptr >= fifo_len);

   always @(posedge clk) begin
      if (fifo_flush)     rd_ptr <= 0;
      else if (FIFO_RD_O) rd_ptr <= rd_ptr + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s (frame %0d line %0d beat %0d): got %h want %h",
                  tag, cur_frame, cur_line, cur_beat, got, exp);
      end
   endtask

   // Drive one cycle of inputs, sample the combinational pop, then move to
   // just after the edge where the registered outputs for that cycle appear.
   task automatic step(input logic vs, input logic hs, input logic de,
                       input logic busy, input logic r);
      VS_I = vs; HS_I = hs; DE_I = de; FIFO_RST_BUSY_I = busy; rst = r;
      #1 rd_now = FIFO_RD_O;
      @(posedge clk);
      #1;
   endtask

   // One frame. Expected pops and underflow count are supplied by the caller.
   task automatic frame(input int x, input int y, input int w, input int h,
                        input logic [15:0] border, input int flen, input int busy_n,
                        input int rst_line, input int rst_beat, input int chg_line,
                        input int exp_pops, input int exp_ufl);
      int          ptr, wbeat;
      logic        act, inw, busy, r, rd_exp;
      logic [63:0] d_exp;
      cur_frame++;
      cur_line = -1; cur_beat = -1;
      WIN_X_I = 16'(x); WIN_Y_I = 16'(y); WIN_W_I = 16'(w); WIN_H_I = 16'(h);
      BORDER_PIX_I = border;
      fifo_len   = flen;
      fifo_flush = 1'b1;
      step(0, 0, 0, 0, 0);
      fifo_flush = 1'b0;
      step(1, 0, 0, 0, 0);
      check("vs_o_high", VS_O, 1'b1);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("vs_o_low", VS_O, 1'b0);
      check("ufl_cnt_clear", UFL_CNT_O, 0);
      check("underflow_flag_start", UNDERFLOW_O, sticky_exp);
      border_exp = {4{border}};
      act = 1'b1; ptr = 0; wbeat = 0;
      for (int l = 0; l < 6; l++) begin
         cur_line = l; cur_beat = -1;
         if (l == chg_line) WIN_X_I = 16'd0;
         step(0, 1, 0, 0, 0);
         check("hs_o", HS_O, 1'b1);
         step(0, 0, 0, 0, 0);
         for (int b = 0; b < 16; b++) begin
            cur_beat = b;
            r      = act && (l == rst_line) && (b == rst_beat);
            inw    = (l >= y) && (l < y + h) && (b >= x) && (b < x + w);
            busy   = act && inw && (wbeat < busy_n);
            rd_exp = act && !r && inw && !busy && (ptr < flen);
            d_exp  = r ? 64'd0 : (rd_exp ? 64'(ptr + 1) : border_exp);
            if (act && inw && !rd_exp && !r) sticky_exp = 1'b1;
            if (act && inw) wbeat++;
            step(0, 0, 1, busy, r);
            check("fifo_rd", rd_now, rd_exp);
            check("de_o", DE_O, act && !r);
            check("data_o", DATA_O, d_exp);
            if (rd_exp) ptr++;
            if (r) begin
               act        = 1'b0;
               border_exp = '0;
               sticky_exp = 1'b0;
            end
         end
         cur_beat = -1;
         for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
      end
      check("pops", 64'(rd_ptr), 64'(exp_pops));
      check("ufl_cnt", UFL_CNT_O, 64'(exp_ufl));
      check("underflow_flag", UNDERFLOW_O, sticky_exp);
   endtask

   initial begin
      WIN_X_I = '0; WIN_Y_I = '0; WIN_W_I = '0; WIN_H_I = '0;
      BORDER_PIX_I = BORDER;
      VS_I = 0; HS_I = 0; DE_I = 0; FIFO_RST_BUSY_I = 0; rst = 1;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
      check("rst_fifo_rd", FIFO_RD_O, 1'b0);
      check("rst_vs_o", VS_O, 1'b0);
      check("rst_hs_o", HS_O, 1'b0);
      check("rst_de_o", DE_O, 1'b0);
      check("rst_data_o", DATA_O, 64'd0);
      check("rst_underflow", UNDERFLOW_O, 1'b0);
      check("rst_ufl_cnt", UFL_CNT_O, 0);
      step(0, 0, 0, 0, 0);

      // x  y  w  h  border   flen busy rstL rstB chg  pops ufl
      frame(4, 1, 8, 3, BORDER,   24, 0, -1, -1, -1,  24,  0);  // basic placement
      frame(4, 1, 8, 3, BORDER,   10, 0, -1, -1, -1,  10, 14);  // underflow
      frame(4, 1, 8, 3, BORDER,   24, 3, -1, -1, -1,  21,  3);  // reset busy, flag still set
      frame(4, 1, 0, 3, BORDER,   24, 0, -1, -1, -1,   0,  0);  // disabled window
      frame(12, 1, 8, 3, 16'h2222, 24, 0, -1, -1, -1, 12,  0);  // oversize, clipped
      frame(4, 1, 8, 3, BORDER,   24, 0,  2,  5, -1,   9,  0);  // reset mid-frame
      frame(4, 1, 8, 3, BORDER,   24, 0, -1, -1, -1,  24,  0);  // recovers after reset
      frame(4, 1, 8, 3, BORDER,   24, 0, -1, -1,  2,  24,  0);  // X changed mid-frame

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard bound so the run always ends even if the stimulus stalls.
   initial begin
      #200000;
      $display("FAIL timeout: got no completion want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vid_scaled_placer.md
Name: vid_scaled_placer

Overview:
- Video-clock stage directly downstream of the scaler's output async FIFO (fwft, C_PORT_NUM pixels per beat).
- Takes DE/HS/VS timing from the video timing generator and places the scaled picture as a rectangular window inside the output active area.
- Pops one FIFO beat per active beat inside the window; drives a border colour everywhere else.
- Detects and counts FIFO underflow inside the window.

Parameters:
- C_PORT_NUM, 4, pixels per beat, both on the FIFO side and on the output side.
- C_BYTES_PER_PIXEL, 2, bytes per pixel.
- C_CNT_W, 16, width of the position counters and the window config fields.

Ports:
- clk  in  1  video clock.
- rst  in  1  reset, synchronous, active-high.
- WIN_X_I  in  C_CNT_W  window left edge, in beats from the first DE beat.
- WIN_Y_I  in  C_CNT_W  window top edge, in active lines.
- WIN_W_I  in  C_CNT_W  window width in beats; 0 disables the window.
- WIN_H_I  in  C_CNT_W  window height in lines; 0 disables the window.
- BORDER_PIX_I  in  C_BYTES_PER_PIXEL*8  border pixel, replicated C_PORT_NUM times.
- VS_I, HS_I, DE_I  in  1 each  input timing.
- FIFO_EMPTY_I  in  1  FIFO empty.
- FIFO_RST_BUSY_I  in  1  FIFO read-side reset busy.
- FIFO_DATA_I  in  C_PORT_NUM*C_BYTES_PER_PIXEL*8  fwft head data.
- FIFO_RD_O  out  1  FIFO pop, combinational.
- VS_O, HS_O, DE_O  out  1 each  timing delayed by 1 cycle.
- DATA_O  out  C_PORT_NUM*C_BYTES_PER_PIXEL*8  output pixels, registered.
- UNDERFLOW_O  out  1  sticky underflow flag.
- UFL_CNT_O  out  C_CNT_W  underflow beats counted in the current frame.

Behaviour:
- vs_rise = VS_I & ~VS_I_d1; de_fall = ~DE_I & DE_I_d1. The edge-detect registers are cleared by rst.
- FSM states: IDLE, ACTIVE.
  - rst forces IDLE from any state, including mid-frame.
  - IDLE -> ACTIVE on vs_rise.
  - ACTIVE stays in ACTIVE; each vs_rise re-arms the frame.
- IDLE behaviour:
  - FIFO_RD_O=0, DE_O=0, DATA_O=border.
  - VS_O and HS_O still follow the inputs with a 1-cycle delay.
- Reset values:
  - FIFO_RD_O, VS_O, HS_O, DE_O, UNDERFLOW_O = 0.
  - DATA_O = 0; UFL_CNT_O = 0.
  - All counters = 0; latched config = 0.
- Latching on vs_rise:
  - Latch WIN_X/Y/W/H and BORDER_PIX from the inputs.
  - Clear x_cnt, y_cnt and UFL_CNT_O.
  - A DE_I coincident with vs_rise is treated as outside the window.
- Counters:
  - x_cnt increments on each DE_I cycle and clears on de_fall.
  - y_cnt increments on de_fall.
  - Both saturate at all-ones; neither wraps.
- Window test: in_win = (y_cnt >= Y) & (y_cnt < Y+H) & (x_cnt >= X) & (x_cnt < X+W).
  - Sums are computed at C_CNT_W+1 bits, so there is no wrap.
  - W=0 or H=0 means in_win=0.
  - A window extending past the active area is clipped implicitly; any unread FIFO data is left for the next VS FIFO reset.
- Data available: avail = ~FIFO_EMPTY_I & ~FIFO_RST_BUSY_I.
- FIFO_RD_O = ACTIVE & DE_I & in_win & avail.
  - FIFO_RD_O is combinational, so FIFO_DATA_I is consumed in the same cycle.
- Output register (latency is exactly 1 cycle for timing and data):
  - FIFO_RD_O=1: DATA_O <= FIFO_DATA_I.
  - Otherwise: DATA_O <= replicated border.
  - DE_O <= DE_I & ACTIVE.
- Underflow: ACTIVE & DE_I & in_win & ~avail in a cycle:
  - Output border for that beat; no pop.
  - Set UNDERFLOW_O; it stays set until rst.
  - UFL_CNT_O increments, saturating.
  - Window position is still consumed: x_cnt advances, so the picture does not shift.
- Pixel lane order is passed through unchanged; lane 0 = LSBs = leftmost pixel.

Test Plan:
- Basic placement:
  - Setup: DE 16 beats/line, 6 lines; X=4, W=8, Y=1, H=3; FIFO preloaded with 24 beats valued 1..24; border 0x1080.
  - Required: 24 pops.
  - Line 1, beats 4..11, output 1..8 one cycle after DE.
  - All other beats output 0x1080 in every lane; UFL_CNT_O=0.
- Underflow:
  - Setup: same window, FIFO holds only 10 beats.
  - Required: 10 pops; the next 14 window beats are border.
  - UNDERFLOW_O=1; UFL_CNT_O=14; UFL_CNT_O clears at the next vs_rise while UNDERFLOW_O stays 1.
- FIFO reset busy:
  - Setup: FIFO_RST_BUSY_I=1 during the first 3 window beats.
  - Required: no pops in those beats; border output; UFL_CNT_O=3.
- Disabled window and oversize window:
  - W=0: FIFO_RD_O never asserts.
  - X=12, W=8: only beats 12..15 pop, 4 per window line; no wrap.
- Reset mid-frame:
  - Stimulus: rst on line 2 beat 5.
  - Required: FSM returns to IDLE; DE_O=0 and no pops until the next vs_rise.
  - The next frame behaves as in the basic placement scenario.
- Config change mid-frame:
  - Stimulus: change WIN_X_I on line 2.
  - Required: no effect until the next vs_rise.
